cp0_exception_commit: RTL and testbench

Commit-side consumer of the encoded exception word produced by the interrupt/exception prioritiser. It owns the CP0 architectural registers (BadVAddr, Count, Compare, Status, Cause, EPC) and decodes each committed exception code. On a decoded exception or `eret` it:
- updates the CP0 registers;
- raises a one-cycle pipeline flush;
- supplies the redirect PC.

It also samples the hardware interrupt lines and runs the Count/Compare timer, which feed back into the Status/Cause words the prioritiser consumes.

---
 rtl/cp0_exception_commit_pkg.sv | 76 +++++++
 rtl/cp0_exception_commit_timer.sv | 51 +++++
 rtl/cp0_exception_commit.sv | 147 ++++++++++++++
 tb/tb_cp0_exception_commit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exception_commit_pkg.sv
// Shared exception encodings, ExcCode values, CP0 register numbers and field positions.
// The interrupt/exception prioritiser imports the same package.
package cp0_exception_commit_pkg;

  localparam logic [31:0] EncNone   = 32'h00;
  localparam logic [31:0] EncInt0   = 32'h01;
  localparam logic [31:0] EncInt7   = 32'h08;
  localparam logic [31:0] EncAdelIf = 32'h09;
  localparam logic [31:0] EncSys    = 32'h0A;
  localparam logic [31:0] EncRi     = 32'h0B;
  localparam logic [31:0] EncOv     = 32'h0C;
  localparam logic [31:0] EncTr     = 32'h0D;
  localparam logic [31:0] EncBp     = 32'h0E;
  localparam logic [31:0] EncAdelLd = 32'h0F;
  localparam logic [31:0] EncAdes   = 32'h10;
  localparam logic [31:0] EncEret   = 32'h11;

  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] ExcAdel = 5'd4;
  localparam logic [4:0] ExcAdes = 5'd5;
  localparam logic [4:0] ExcSys  = 5'd8;
  localparam logic [4:0] ExcBp   = 5'd9;
  localparam logic [4:0] ExcRi   = 5'd10;
  localparam logic [4:0] ExcOv   = 5'd12;
  localparam logic [4:0] ExcTr   = 5'd13;

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;

  localparam int unsigned StatusBev = 22;
  localparam int unsigned StatusExl = 1;
  localparam int unsigned StatusIe  = 0;
  localparam int unsigned CauseBd   = 31;
  localparam int unsigned CauseTi   = 30;

  typedef enum logic [1:0] {BadvNone, BadvPc, BadvAddr} badv_sel_e;

  typedef struct packed {
    logic       exc;
    logic       eret;
    logic [4:0] exc_code;
    badv_sel_e  badv_sel;
  } exc_dec_t;

  // Unknown non-zero codes fall through to the reserved-instruction default.
  function automatic exc_dec_t decode_exc(input logic [31:0] code);
    exc_dec_t dec;
    dec = '{exc: 1'b1, eret: 1'b0, exc_code: ExcRi, badv_sel: BadvNone};
    if (code == EncNone) begin
      dec.exc = 1'b0;
    end else if (code == EncEret) begin
      dec.exc  = 1'b0;
      dec.eret = 1'b1;
    end else if (code >= EncInt0 && code <= EncInt7) begin
      dec.exc_code = ExcInt;
    end else begin
      case (code)
        EncAdelIf: begin dec.exc_code = ExcAdel; dec.badv_sel = BadvPc;   end
        EncAdelLd: begin dec.exc_code = ExcAdel; dec.badv_sel = BadvAddr; end
        EncAdes:   begin dec.exc_code = ExcAdes; dec.badv_sel = BadvAddr; end
        EncSys:    dec.exc_code = ExcSys;
        EncBp:     dec.exc_code = ExcBp;
        EncRi:     dec.exc_code = ExcRi;
        EncOv:     dec.exc_code = ExcOv;
        EncTr:     dec.exc_code = ExcTr;
        default:   dec.exc_code = ExcRi;
      endcase
    end
    return dec;
  endfunction

endpackage

// File: rtl/cp0_exception_commit_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, TI latches on a match.
module cp0_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic        toggle_q, toggle_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    toggle_d  = ~toggle_q;
    count_d   = toggle_q ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) count_d = wdata_i;
    // A Compare write acknowledges the interrupt even if a match happens this cycle.
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if (count_q == compare_q && compare_q != 32'd0) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      toggle_q  <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      toggle_q  <= toggle_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exception_commit.sv
// Commit-side CP0: decodes the committed exception word, owns the CP0 registers,
// and raises flush plus redirect PC for exceptions and eret.
module cp0_exception_commit
  import cp0_exception_commit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [4:0]  cp0_raddr_i,
  output logic [31:0] cp0_rdata_o,
  input  logic [5:0]  hw_int_i,
  output logic [31:0] cp0_status_o,
  output logic [31:0] cp0_cause_o,
  output logic [31:0] cp0_epc_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  exc_dec_t    dec;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [31:0] count, compare;
  logic        ti;

  assign dec = decode_exc(excepttype_i);

  cp0_timer u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .count_we_i   (cp0_we_i && (cp0_waddr_i == RegCount)),
    .compare_we_i (cp0_we_i && (cp0_waddr_i == RegCompare)),
    .wdata_i      (cp0_wdata_i),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  // mtc0 is applied first so that exception/eret updates override shared fields.
  always_comb begin
    badvaddr_d = badvaddr_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = {hw_int_i[5] | ti, hw_int_i[4:0]};
    if (cp0_we_i) begin
      case (cp0_waddr_i)
        RegStatus: begin
          im_d  = cp0_wdata_i[15:8];
          exl_d = cp0_wdata_i[StatusExl];
          ie_d  = cp0_wdata_i[StatusIe];
        end
        RegCause: ip_sw_d = cp0_wdata_i[9:8];
        RegEpc:   epc_d   = cp0_wdata_i;
        default: ;
      endcase
    end
    if (dec.exc) begin
      exc_code_d = dec.exc_code;
      exl_d      = 1'b1;
      if (!exl_q) begin
        epc_d = is_in_delayslot_i ? current_inst_pc_i - 32'd4 : current_inst_pc_i;
        bd_d  = is_in_delayslot_i;
      end
      if (dec.badv_sel == BadvPc)   badvaddr_d = current_inst_pc_i;
      if (dec.badv_sel == BadvAddr) badvaddr_d = bad_addr_i;
    end else if (dec.eret) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      badvaddr_q <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
    end
  end

  always_comb begin
    cp0_status_o             = '0;
    cp0_status_o[StatusBev]  = 1'b1;
    cp0_status_o[15:8]       = im_q;
    cp0_status_o[StatusExl]  = exl_q;
    cp0_status_o[StatusIe]   = ie_q;
    cp0_cause_o              = '0;
    cp0_cause_o[CauseBd]     = bd_q;
    cp0_cause_o[CauseTi]     = ti;
    cp0_cause_o[15:10]       = ip_hw_q;
    cp0_cause_o[9:8]         = ip_sw_q;
    cp0_cause_o[6:2]         = exc_code_q;
  end

  assign cp0_epc_o = epc_q;
  assign flush_o   = resetn && (dec.exc || dec.eret);
  assign new_pc_o  = (resetn && dec.eret) ? epc_q : EXC_VECTOR;

  always_comb begin
    cp0_rdata_o = '0;
    if (resetn) begin
      case (cp0_raddr_i)
        RegBadVAddr: cp0_rdata_o = badvaddr_q;
        RegCount:    cp0_rdata_o = count;
        RegCompare:  cp0_rdata_o = compare;
        RegStatus:   cp0_rdata_o = cp0_status_o;
        RegCause:    cp0_rdata_o = cp0_cause_o;
        RegEpc:      cp0_rdata_o = epc_q;
        default:     cp0_rdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exception_commit.sv
// Self-checking bench for cp0_exception_commit: directed scenarios plus a randomized run
// against a whole-register behavioural model.
module tb_cp0_exception_commit;

  localparam logic [31:0] Vec = 32'hBFC0_0380;

  logic        clk;
  logic        resetn;
  logic [31:0] excepttype;
  logic [31:0] pc;
  logic        ds;
  logic [31:0] bad_addr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic [31:0] status, cause, epc;
  logic        flush;
  logic [31:0] new_pc;

  int checks;
  int failures;

  logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
  logic        m_tog, m_ti;

  cp0_exception_commit #(.EXC_VECTOR(Vec)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .excepttype_i      (excepttype),
    .current_inst_pc_i (pc),
    .is_in_delayslot_i (ds),
    .bad_addr_i        (bad_addr),
    .cp0_we_i          (we),
    .cp0_waddr_i       (waddr),
    .cp0_wdata_i       (wdata),
    .cp0_raddr_i       (raddr),
    .cp0_rdata_o       (rdata),
    .hw_int_i          (hw_int),
    .cp0_status_o      (status),
    .cp0_cause_o       (cause),
    .cp0_epc_o         (epc),
    .flush_o           (flush),
    .new_pc_o          (new_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] exc_code_of(input logic [31:0] c);
    if (c >= 32'd1 && c <= 32'd8) return 5'd0;
    case (c)
      32'h09, 32'h0F: return 5'd4;
      32'h10:         return 5'd5;
      32'h0A:         return 5'd8;
      32'h0E:         return 5'd9;
      32'h0B:         return 5'd10;
      32'h0C:         return 5'd12;
      32'h0D:         return 5'd13;
      default:        return 5'd10;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (!resetn) return 32'd0;
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    logic [31:0] ns, nc, nepc, nbadv, ncount, ncomp;
    logic        nti;
    if (!resetn) begin
      m_status = 32'h0040_0000; m_cause = '0; m_epc = '0; m_badv = '0;
      m_count = '0; m_compare = '0; m_tog = 1'b0; m_ti = 1'b0;
    end else begin
      ns = m_status; nc = m_cause; nepc = m_epc; nbadv = m_badv;
      ncount = m_count + (m_tog ? 32'd1 : 32'd0);
      ncomp = m_compare;
      nti = m_ti | (m_count == m_compare && m_compare != 32'd0);
      if (we) begin
        case (waddr)
          5'd9:  ncount = wdata;
          5'd11: begin ncomp = wdata; nti = 1'b0; end
          5'd12: ns = (ns & ~32'h0000_FF03) | (wdata & 32'h0000_FF03);
          5'd13: nc = (nc & ~32'h0000_0300) | (wdata & 32'h0000_0300);
          5'd14: nepc = wdata;
          default: ;
        endcase
      end
      nc[15:10] = {hw_int[5] | m_ti, hw_int[4:0]};
      nc[30] = nti;
      if (excepttype != 32'd0 && excepttype != 32'h11) begin
        nc[6:2] = exc_code_of(excepttype);
        if (!m_status[1]) begin
          nepc = ds ? pc - 32'd4 : pc;
          nc[31] = ds;
        end
        ns[1] = 1'b1;
        if (excepttype == 32'h09) nbadv = pc;
        if (excepttype == 32'h0F || excepttype == 32'h10) nbadv = bad_addr;
      end else if (excepttype == 32'h11) begin
        ns[1] = 1'b0;
      end
      m_status = ns; m_cause = nc; m_epc = nepc; m_badv = nbadv;
      m_count = ncount; m_compare = ncomp; m_ti = nti; m_tog = ~m_tog;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; excepttype = 32'h0C; raddr = 5'd12;
    tick();
    #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got %h want 0", flush); end
    checks++; if (new_pc !== Vec) begin failures++; $display("FAIL reset_new_pc got %h want %h", new_pc, Vec); end
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got %h want 0", rdata); end
    tick();
    resetn = 1'b1; excepttype = '0;
    for (int i = 0; i < 10; i++) tick();
    #1;
    checks++; if (rdata !== 32'h0040_0000) begin failures++; $display("FAIL reset_status got %h want 00400000", rdata); end
    raddr = 5'd9; #1;
    checks++; if (rdata !== 32'd5) begin failures++; $display("FAIL reset_count got %h want 5", rdata); end
    checks++; if (cause !== 32'd0) begin failures++; $display("FAIL reset_cause got %h want 0", cause); end
    checks++; if (epc !== 32'd0) begin failures++; $display("FAIL reset_epc got %h want 0", epc); end
  endtask

  task automatic test_exc_delay_slot();
    excepttype = 32'h0C; pc = 32'h8000_1000; ds = 1'b1;
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL ov_flush got %h want 1", flush); end
    checks++; if (new_pc !== Vec) begin failures++; $display("FAIL ov_new_pc got %h want %h", new_pc, Vec); end
    tick();
    excepttype = '0; ds = 1'b0; #1;
    checks++; if (epc !== 32'h8000_0FFC) begin failures++; $display("FAIL ov_epc got %h want 80000ffc", epc); end
    checks++; if (cause[31] !== 1'b1) begin failures++; $display("FAIL ov_bd got %h want 1", cause[31]); end
    checks++; if (cause[6:2] !== 5'd12) begin failures++; $display("FAIL ov_exccode got %0d want 12", cause[6:2]); end
    checks++; if (status[1] !== 1'b1) begin failures++; $display("FAIL ov_exl got %h want 1", status[1]); end
  endtask

  task automatic test_nested_ades();
    excepttype = 32'h10; bad_addr = 32'h1234_5671; pc = 32'h8000_3000; ds = 1'b0;
    tick();
    excepttype = '0; raddr = 5'd8; #1;
    checks++; if (epc !== 32'h8000_0FFC) begin failures++; $display("FAIL ades_epc got %h want 80000ffc", epc); end
    checks++; if (rdata !== 32'h1234_5671) begin failures++; $display("FAIL ades_badv got %h want 12345671", rdata); end
    checks++; if (cause[6:2] !== 5'd5) begin failures++; $display("FAIL ades_exccode got %0d want 5", cause[6:2]); end
    checks++; if (cause[31] !== 1'b1) begin failures++; $display("FAIL ades_bd got %h want 1", cause[31]); end
  endtask

  task automatic test_eret();
    we = 1'b1; waddr = 5'd14; wdata = 32'h8000_2000;
    tick();
    we = 1'b0; excepttype = 32'h11; #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL eret_flush got %h want 1", flush); end
    checks++; if (new_pc !== 32'h8000_2000) begin failures++; $display("FAIL eret_new_pc got %h want 80002000", new_pc); end
    tick();
    excepttype = '0; #1;
    checks++; if (status[1] !== 1'b0) begin failures++; $display("FAIL eret_exl got %h want 0", status[1]); end
  endtask

  task automatic test_timer();
    logic seen;
    seen = 1'b0; hw_int = '0;
    we = 1'b1; waddr = 5'd11; wdata = 32'd4;
    tick();
    waddr = 5'd9; wdata = 32'd0;
    tick();
    we = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      tick();
      if (cause[30] === 1'b1 && cause[15] === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL timer_ti cause %h want bits 30 and 15 set", cause); end
    we = 1'b1; waddr = 5'd11; wdata = 32'd1000;
    tick();
    we = 1'b0; #1;
    checks++; if (cause[30] !== 1'b0) begin failures++; $display("FAIL timer_ti_clear got %h want 0", cause[30]); end
  endtask

  task automatic test_status_collision();
    we = 1'b1; waddr = 5'd12; wdata = 32'h0000_FF01; excepttype = 32'h0A;
    tick();
    we = 1'b0; excepttype = '0; #1;
    checks++; if (status[15:8] !== 8'hFF) begin failures++; $display("FAIL coll_im got %h want ff", status[15:8]); end
    checks++; if (status[0] !== 1'b1) begin failures++; $display("FAIL coll_ie got %h want 1", status[0]); end
    checks++; if (status[1] !== 1'b1) begin failures++; $display("FAIL coll_exl got %h want 1", status[1]); end
    checks++; if (cause[6:2] !== 5'd8) begin failures++; $display("FAIL coll_exccode got %0d want 8", cause[6:2]); end
  endtask

  task automatic test_random();
    logic [4:0]  tab [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    logic        exp_flush;
    logic [31:0] exp_pc, exp_rd;
    int unsigned r;
    for (int i = 0; i < 600; i++) begin
      resetn = ($urandom_range(0, 99) != 0);
      r = $urandom_range(0, 9);
      if (r < 5) excepttype = '0;
      else if (r < 9) excepttype = 32'($urandom_range(1, 17));
      else excepttype = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(18, 40));
      pc = $urandom & 32'hFFFF_FFFC; ds = 1'($urandom_range(0, 1));
      bad_addr = $urandom; hw_int = 6'($urandom_range(0, 63));
      we = ($urandom_range(0, 2) == 0);
      waddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : tab[$urandom_range(0, 6)];
      wdata = (waddr == 5'd9 || waddr == 5'd11) ? 32'($urandom_range(0, 20)) : $urandom;
      raddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : tab[$urandom_range(0, 6)];
      #1;
      exp_flush = resetn && (excepttype != 32'd0);
      exp_pc = (resetn && excepttype == 32'h11) ? m_epc : Vec;
      exp_rd = model_read(raddr);
      checks++; if (flush !== exp_flush) begin failures++; $display("FAIL rnd_flush cyc %0d got %h want %h", i, flush, exp_flush); end
      checks++; if (new_pc !== exp_pc) begin failures++; $display("FAIL rnd_new_pc cyc %0d got %h want %h", i, new_pc, exp_pc); end
      checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL rnd_rdata cyc %0d reg %0d got %h want %h", i, raddr, rdata, exp_rd); end
      tick();
      checks++; if (status !== m_status) begin failures++; $display("FAIL rnd_status cyc %0d got %h want %h", i, status, m_status); end
      checks++; if (cause !== m_cause) begin failures++; $display("FAIL rnd_cause cyc %0d got %h want %h", i, cause, m_cause); end
      checks++; if (epc !== m_epc) begin failures++; $display("FAIL rnd_epc cyc %0d got %h want %h", i, epc, m_epc); end
    end
    resetn = 1'b1; excepttype = '0; we = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    resetn = 1'b0; excepttype = '0; pc = '0; ds = 1'b0; bad_addr = '0;
    we = 1'b0; waddr = '0; wdata = '0; raddr = '0; hw_int = '0;
    test_reset();
    test_exc_delay_slot();
    test_nested_ades();
    test_eret();
    test_timer();
    test_status_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
